// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the fetch-stage program counter.
//   FETCH_PC_WIDTH     default PC / address width
//   FETCH_RESET_VECTOR default PC after reset and while trigger is low
//   FETCH_RAS_DEPTH    default return-address-stack depth
//   pc_sel_e           next-PC source chosen by the selection logic
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int          FETCH_PC_WIDTH     = 32;
    localparam logic [31:0] FETCH_RESET_VECTOR = 32'hBFC0_0000;
    localparam int          FETCH_RAS_DEPTH    = 4;

    typedef enum logic [2:0] {
        PC_RESET,
        PC_REDIRECT,
        PC_HOLD,
        PC_RET,
        PC_SEQ
    } pc_sel_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundles the control, hint and status signals of the fetch PC unit.
//   master : drives trigger/stall/redirect/call/ret, observes pc and status
//   slave  : the PC unit itself
// Signals:
//   trigger, stall                  run enable and pipeline hold
//   redirect_valid, redirect_pc     resolved redirect from execute
//   call_valid, call_ret_addr       call hint from decode (push)
//   ret_valid                       return hint from decode (pop)
//   pc, pc_plus4                    fetch address and its sequential successor
//   misalign, ras_miss, ras_count   status
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH  = FETCH_PC_WIDTH,
    parameter int RAS_DEPTH = FETCH_RAS_DEPTH
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic                trigger;
    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                call_valid;
    logic [PC_WIDTH-1:0] call_ret_addr;
    logic                ret_valid;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                misalign;
    logic                ras_miss;
    logic [CNT_W-1:0]    ras_count;

    modport master (
        output trigger, stall, redirect_valid, redirect_pc,
               call_valid, call_ret_addr, ret_valid,
        input  pc, pc_plus4, misalign, ras_miss, ras_count
    );

    modport slave (
        input  trigger, stall, redirect_valid, redirect_pc,
               call_valid, call_ret_addr, ret_valid,
        output pc, pc_plus4, misalign, ras_miss, ras_count
    );

endinterface : fetch_pc_unit_if

// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
// Circular return-address stack with a top pointer. Pushing onto a full stack
// overwrites the oldest entry; push and pop together replace the top entry.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the stack)
//   push_i         write push_data_i as the new top
//   pop_i          discard the top entry (ignored while empty)
//   push_data_i    address to push
//   top_o          current top entry (valid only when !empty_o)
//   count_o        number of valid entries, 0..RAS_DEPTH
//   empty_o/full_o occupancy flags
// -----------------------------------------------------------------------------
module return_addr_stack
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH  = FETCH_PC_WIDTH,
    parameter int RAS_DEPTH = FETCH_RAS_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_i,
    input  logic                             pop_i,
    input  logic [PC_WIDTH-1:0]              push_data_i,
    output logic [PC_WIDTH-1:0]              top_o,
    output logic [$clog2(RAS_DEPTH):0]       count_o,
    output logic                             empty_o,
    output logic                             full_o
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]    top_q,   top_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                wr_en;
    logic [PTR_W-1:0]    wr_ptr;
    logic                do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(RAS_DEPTH));
    assign top_o   = mem_q[top_q];
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_ptr  = top_q;
        case ({push_i, do_pop})
            2'b10: begin
                // Pointer wraps, so a push onto a full stack lands on the oldest slot.
                top_d  = top_q + PTR_W'(1);
                wr_ptr = top_q + PTR_W'(1);
                wr_en  = 1'b1;
                if (!full_o) count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                // Return consumes the old top, the call refills the same slot.
                wr_en  = 1'b1;
                wr_ptr = top_q;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry array has no reset; count_q alone defines which
    // entries are valid, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= push_data_i;
    end

endmodule : return_addr_stack

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage program counter with prioritised next-PC selection:
// reset > !trigger > execute redirect > stall > RAS return > sequential.
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous, active-high reset
//   bus   fetch_pc_unit_if.slave (control/hint inputs, pc and status outputs)
// Configuration:
//   FETCH_RAS_EN  when defined, a return-address stack predicts ret targets
//                 from decode hints; otherwise call/ret hints are ignored and
//                 ras_miss/ras_count are tied to 0.
// -----------------------------------------------------------------------------
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = FETCH_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(FETCH_RESET_VECTOR),
    parameter int                  RAS_DEPTH    = FETCH_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                misalign_q, misalign_d;
    logic                ret_hit;
    logic [PC_WIDTH-1:0] ras_top;
    pc_sel_e             pc_sel;

    assign pc_plus4     = pc_q + PC_WIDTH'(4);
    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.misalign = misalign_q;

`ifdef FETCH_RAS_EN
    logic             hint_ok;
    logic             ras_push, ras_pop;
    logic             ras_empty;
    logic             unused_ras_full;
    logic [CNT_W-1:0] ras_count;
    logic             ras_miss_q, ras_miss_d;

    // Decode hints are on the wrong path under a redirect and are stale under
    // stall or while the core is parked, so only a free-running cycle accepts them.
    assign hint_ok    = bus.trigger && !bus.redirect_valid && !bus.stall;
    assign ras_push   = hint_ok && bus.call_valid;
    assign ras_pop    = hint_ok && bus.ret_valid && !ras_empty;
    assign ras_miss_d = hint_ok && bus.ret_valid && ras_empty;
    assign ret_hit    = ras_pop;

    return_addr_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (bus.call_ret_addr),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .empty_o     (ras_empty),
        .full_o      (unused_ras_full)
    );

    always_ff @(posedge clk) begin
        if (rst) ras_miss_q <= 1'b0;
        else     ras_miss_q <= ras_miss_d;
    end

    assign bus.ras_miss  = ras_miss_q;
    assign bus.ras_count = ras_count;
`else
    logic unused_hints;

    assign unused_hints  = ^{bus.call_valid, bus.ret_valid, bus.call_ret_addr};
    assign ret_hit       = 1'b0;
    assign ras_top       = '0;
    assign bus.ras_miss  = 1'b0;
    assign bus.ras_count = CNT_W'(0);
`endif

    // Reset is applied in the register itself, so it outranks every source here.
    always_comb begin
        pc_sel = PC_SEQ;
        if (!bus.trigger)           pc_sel = PC_RESET;
        else if (bus.redirect_valid) pc_sel = PC_REDIRECT;
        else if (bus.stall)          pc_sel = PC_HOLD;
        else if (ret_hit)            pc_sel = PC_RET;
    end

    always_comb begin
        case (pc_sel)
            PC_RESET:    pc_d = RESET_VECTOR;
            PC_REDIRECT: pc_d = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
            PC_HOLD:     pc_d = pc_q;
            PC_RET:      pc_d = ras_top;
            default:     pc_d = pc_plus4;
        endcase
    end

    assign misalign_d = (pc_sel == PC_REDIRECT) && (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Self-checking bench for fetch_pc_unit. A behavioural model (PC value plus a
// queue used as the return stack) advances once per clock edge from the same
// inputs the DUT sees; directed scenarios and a random run compare against it.
// Builds with or without FETCH_RAS_EN.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam int          PW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'hBFC0_0000;
`ifdef FETCH_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_pc_unit_if #(.PC_WIDTH(PW), .RAS_DEPTH(DEPTH)) bus ();

    fetch_pc_unit #(
        .PC_WIDTH     (PW),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_mis;
    bit          m_miss;
    logic [31:0] m_ras[$];

    task automatic idle();
        rst                = 1'b0;
        bus.trigger        = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.call_valid     = 1'b0;
        bus.call_ret_addr  = '0;
        bus.ret_valid      = 1'b0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic [31:0] tgt;
        bit          hit;
        @(posedge clk);
        hit    = 1'b0;
        tgt    = '0;
        m_mis  = 1'b0;
        m_miss = 1'b0;
        if (rst) begin
            m_pc = RV;
            m_ras.delete();
        end else if (!bus.trigger) begin
            m_pc = RV;
        end else if (bus.redirect_valid) begin
            m_pc  = bus.redirect_pc & ~32'h3;
            m_mis = (bus.redirect_pc % 4) != 0;
        end else if (!bus.stall) begin
            if (RAS_EN && bus.ret_valid) begin
                if (m_ras.size() == 0) m_miss = 1'b1;
                else begin
                    tgt = m_ras.pop_back();
                    hit = 1'b1;
                end
            end
            if (RAS_EN && bus.call_valid) begin
                m_ras.push_back(bus.call_ret_addr);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = hit ? tgt : m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst         = 1'b1;
        bus.trigger = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.pc !== 32'hBFC0_0000) begin n_bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'hBFC0_0000); end
        n_cmp++; if (bus.misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", bus.misalign); end
        n_cmp++; if (bus.ras_miss !== 1'b0) begin n_bad++; $display("FAIL reset_ras_miss: got %b want 0", bus.ras_miss); end
        n_cmp++; if (bus.ras_count !== 3'd0) begin n_bad++; $display("FAIL reset_ras_count: got %0d want 0", bus.ras_count); end
        bus.trigger = 1'b1;
        tick();
        n_cmp++; if (bus.pc !== 32'hBFC0_0004) begin n_bad++; $display("FAIL run_pc1: got %h want %h", bus.pc, 32'hBFC0_0004); end
        tick();
        n_cmp++; if (bus.pc !== 32'hBFC0_0008) begin n_bad++; $display("FAIL run_pc2: got %h want %h", bus.pc, 32'hBFC0_0008); end
        n_cmp++; if (bus.pc_plus4 !== 32'hBFC0_000C) begin n_bad++; $display("FAIL run_pc_plus4: got %h want %h", bus.pc_plus4, 32'hBFC0_000C); end
        bus.trigger = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== RV) begin n_bad++; $display("FAIL trigger_drop: got %h want %h", bus.pc, RV); end
        // Mid-stream reset beats a redirect in the same cycle.
        idle();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_2002;
        rst                = 1'b1;
        tick();
        n_cmp++; if (bus.pc !== RV || bus.misalign !== 1'b0) begin n_bad++; $display("FAIL reset_wins: got pc=%h mis=%b want pc=%h mis=0", bus.pc, bus.misalign, RV); end
        idle();
    endtask

    task automatic test_stall_redirect();
        logic [31:0] held;
        idle();
        tick();
        held      = bus.pc;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.pc !== held) begin n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, bus.pc, held); end
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_1003;
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_1000) begin n_bad++; $display("FAIL stall_redirect_pc: got %h want %h", bus.pc, 32'h0000_1000); end
        n_cmp++; if (bus.misalign !== 1'b1) begin n_bad++; $display("FAIL misalign_set: got %b want 1", bus.misalign); end
        idle();
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_1004 || bus.misalign !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse: got pc=%h mis=%b want pc=00001004 mis=0", bus.pc, bus.misalign); end
    endtask

    task automatic test_call_ret();
        do_reset();
        idle();
        bus.call_valid = 1'b1; bus.call_ret_addr = 32'h100; tick();
        bus.call_ret_addr = 32'h200; tick();
        bus.call_valid = 1'b0;
        n_cmp++; if (bus.ras_count !== 3'(m_ras.size())) begin n_bad++; $display("FAIL call_count: got %0d want %0d", bus.ras_count, m_ras.size()); end
        bus.ret_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL ret_pc%0d: got %h want %h", i, bus.pc, m_pc); end
            n_cmp++; if (bus.ras_count !== 3'(m_ras.size())) begin n_bad++; $display("FAIL ret_count%0d: got %0d want %0d", i, bus.ras_count, m_ras.size()); end
        end
        idle();
    endtask

    task automatic test_ras_overflow();
        do_reset();
        idle();
        bus.call_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.call_ret_addr = 32'hA000 + 32'(i) * 32'h10;
            tick();
        end
        bus.call_valid = 1'b0;
        n_cmp++; if (bus.ras_count !== 3'(m_ras.size())) begin n_bad++; $display("FAIL full_count: got %0d want %0d", bus.ras_count, m_ras.size()); end
        bus.ret_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL overflow_ret%0d_pc: got %h want %h", i, bus.pc, m_pc); end
            n_cmp++; if (bus.ras_miss !== m_miss) begin n_bad++; $display("FAIL overflow_ret%0d_miss: got %b want %b", i, bus.ras_miss, m_miss); end
        end
        idle();
        tick();
        n_cmp++; if (bus.ras_miss !== 1'b0) begin n_bad++; $display("FAIL miss_pulse: got %b want 0", bus.ras_miss); end
    endtask

    task automatic test_simultaneous();
        logic [2:0] cnt_before;
        do_reset();
        idle();
        bus.call_valid = 1'b1; bus.call_ret_addr = 32'h300; tick();
        cnt_before    = bus.ras_count;
        bus.call_ret_addr = 32'h400;
        bus.ret_valid = 1'b1;
        tick();
        n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL callret_pc: got %h want %h", bus.pc, m_pc); end
        n_cmp++; if (bus.ras_count !== cnt_before) begin n_bad++; $display("FAIL callret_count: got %0d want %0d", bus.ras_count, cnt_before); end
        bus.call_valid = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL callret_newtop: got %h want %h", bus.pc, m_pc); end
        // Redirect beats ret; the stack must keep its entry.
        idle();
        bus.call_valid = 1'b1; bus.call_ret_addr = 32'h500; tick();
        bus.call_valid     = 1'b0;
        cnt_before         = bus.ras_count;
        bus.ret_valid      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_3000;
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_3000) begin n_bad++; $display("FAIL redirect_over_ret_pc: got %h want %h", bus.pc, 32'h0000_3000); end
        n_cmp++; if (bus.ras_count !== cnt_before) begin n_bad++; $display("FAIL redirect_over_ret_count: got %0d want %0d", bus.ras_count, cnt_before); end
        // Parked core keeps the stack; a later ret still finds the entry.
        bus.redirect_valid = 1'b0;
        bus.trigger        = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== RV || bus.ras_count !== cnt_before) begin n_bad++; $display("FAIL park_keeps_ras: got pc=%h cnt=%0d want pc=%h cnt=%0d", bus.pc, bus.ras_count, RV, cnt_before); end
        bus.trigger = 1'b1;
        tick();
        n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL ret_after_park: got %h want %h", bus.pc, m_pc); end
        idle();
    endtask

    task automatic test_wrap();
        idle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        n_cmp++; if (bus.pc_plus4 !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_plus4: got %h want 00000000", bus.pc_plus4); end
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_pc: got %h want 00000000", bus.pc); end
    endtask

    task automatic test_random();
        do_reset();
        idle();
        for (int i = 0; i < 600; i++) begin
            rst                = ($urandom_range(0, 79) == 0);
            bus.trigger        = ($urandom_range(0, 11) != 0);
            bus.stall          = ($urandom_range(0, 3) == 0);
            bus.redirect_valid = ($urandom_range(0, 5) == 0);
            bus.redirect_pc    = $urandom();
            bus.call_valid     = ($urandom_range(0, 2) == 0);
            bus.call_ret_addr  = $urandom() & ~32'h3;
            bus.ret_valid      = ($urandom_range(0, 2) == 0);
            tick();
            n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL rand%0d_pc: got %h want %h", i, bus.pc, m_pc); end
            n_cmp++; if (bus.pc_plus4 !== m_pc + 32'd4) begin n_bad++; $display("FAIL rand%0d_plus4: got %h want %h", i, bus.pc_plus4, m_pc + 32'd4); end
            n_cmp++; if (bus.misalign !== m_mis) begin n_bad++; $display("FAIL rand%0d_misalign: got %b want %b", i, bus.misalign, m_mis); end
            n_cmp++; if (bus.ras_miss !== m_miss) begin n_bad++; $display("FAIL rand%0d_ras_miss: got %b want %b", i, bus.ras_miss, m_miss); end
            n_cmp++; if (bus.ras_count !== 3'(m_ras.size())) begin n_bad++; $display("FAIL rand%0d_ras_count: got %0d want %0d", i, bus.ras_count, m_ras.size()); end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_stall_redirect();
        test_call_ret();
        test_ras_overflow();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_pc_unit
